// File: rtl/param_combo_lock_if.sv
// Interface for param_combo_lock: the digit-entry inputs and the registered
// status outputs, with a master (keypad side) and a slave (lock side) view.
interface param_combo_lock_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int MAX_FAILS  = 3
);
  localparam int DC_W = $clog2(NUM_DIGITS + 1);
  localparam int FC_W = $clog2(MAX_FAILS + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               clear;
  logic               prog_start;

  logic               is_open;
  logic               is_closed;
  logic               locked_out;
  logic               digit_err;
  logic [DIGIT_W-1:0] digit_echo;
  logic [DC_W-1:0]    digits_entered;
  logic [FC_W-1:0]    fail_count;
  logic [2:0]         state_out;

  modport master (
    output digit_in, digit_valid, clear, prog_start,
    input  is_open, is_closed, locked_out, digit_err, digit_echo,
           digits_entered, fail_count, state_out
  );

  modport slave (
    input  digit_in, digit_valid, clear, prog_start,
    output is_open, is_closed, locked_out, digit_err, digit_echo,
           digits_entered, fail_count, state_out
  );
endinterface

// File: rtl/param_combo_lock.sv
// Parametrised combination lock with failed-attempt lockout.
// Define COMBO_PROG_EN to allow reprogramming the combination from OPEN.
module param_combo_lock #(
  parameter int                            NUM_DIGITS     = 6,
  parameter int                            DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] COMBO          = 24'h703262,
  parameter int                            MAX_FAILS      = 3,
  parameter int                            LOCKOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                reset,
  param_combo_lock_if.slave  bus
);
  localparam int CW   = NUM_DIGITS * DIGIT_W;
  localparam int DC_W = $clog2(NUM_DIGITS + 1);
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int LC_W = $clog2(LOCKOUT_CYCLES);

  localparam logic [DC_W-1:0]    LAST_IDX  = DC_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]    FAIL_MAX  = FC_W'(MAX_FAILS);
  localparam logic [FC_W-1:0]    FAIL_LAST = FC_W'(MAX_FAILS - 1);
  localparam logic [LC_W-1:0]    LC_LOAD   = LC_W'(LOCKOUT_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] MAX_DEC   = DIGIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSED  = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  state_t             state;
  logic [CW-1:0]      combo_q;
  logic               mismatch;
  logic [LC_W-1:0]    lock_cnt;
  logic               open_q, closed_q, locked_q, err_q;
  logic [DIGIT_W-1:0] echo_q;
  logic [DC_W-1:0]    count_q;
  logic [FC_W-1:0]    fail_q;

`ifndef COMBO_PROG_EN
  assign combo_q = COMBO;
  logic unused_prog;
  assign unused_prog = bus.prog_start;
`endif

  // Combination digit for the current position; the index is clamped so the
  // select stays in range while the count sits at NUM_DIGITS.
  logic [DC_W-1:0]    digit_idx;
  logic [DIGIT_W-1:0] expected_digit;
  logic               digit_bad, last_digit, attempt_bad;

  // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    digit_idx      = (count_q > LAST_IDX) ? LAST_IDX : count_q;
    expected_digit = combo_q[(NUM_DIGITS - 1 - int'(digit_idx)) * DIGIT_W +: DIGIT_W];
    digit_bad      = (bus.digit_in > MAX_DEC) || (bus.digit_in != expected_digit);
    last_digit     = (count_q == LAST_IDX);
    attempt_bad    = mismatch || digit_bad;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mismatch <= 1'b0;
      lock_cnt <= '0;
      open_q   <= 1'b0;
      closed_q <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      echo_q   <= '0;
      count_q  <= '0;
      fail_q   <= '0;
`ifdef COMBO_PROG_EN
      // NOTE: the combination register is deliberately reset so a reset always restores the built-in code.
      combo_q  <= COMBO;
`endif
    end else begin
      case (state)
        S_IDLE, S_ENTER: begin
          if (bus.digit_valid) begin
            echo_q  <= bus.digit_in;
            err_q   <= (bus.digit_in > MAX_DEC);
            count_q <= count_q + 1'b1;
            if (!last_digit) begin
              state    <= S_ENTER;
              mismatch <= attempt_bad;
            end else begin
              mismatch <= 1'b0;
              if (!attempt_bad) begin
                state  <= S_OPEN;
                open_q <= 1'b1;
                fail_q <= '0;
              end else if (fail_q == FAIL_LAST) begin
                state    <= S_LOCKOUT;
                locked_q <= 1'b1;
                fail_q   <= FAIL_MAX;
                lock_cnt <= LC_LOAD;
              end else begin
                state    <= S_CLOSED;
                closed_q <= 1'b1;
                fail_q   <= fail_q + 1'b1;
              end
            end
          end
        end

        S_OPEN: begin
`ifdef COMBO_PROG_EN
          if (bus.prog_start) begin
            state   <= S_PROG;
            open_q  <= 1'b0;
            count_q <= '0;
          end else
`endif
          if (bus.clear) begin
            state    <= S_IDLE;
            open_q   <= 1'b0;
            count_q  <= '0;
            mismatch <= 1'b0;
          end
        end

        S_CLOSED: begin
          if (bus.clear) begin
            state    <= S_IDLE;
            closed_q <= 1'b0;
            count_q  <= '0;
            mismatch <= 1'b0;
          end
        end

        // Clear and digit strobes are ignored for the whole timed lockout.
        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state    <= S_IDLE;
            locked_q <= 1'b0;
            fail_q   <= '0;
            count_q  <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

`ifdef COMBO_PROG_EN
        S_PROG: begin
          if (bus.clear) begin
            state   <= S_IDLE;
            count_q <= '0;
          end else if (bus.digit_valid) begin
            echo_q  <= bus.digit_in;
            err_q   <= (bus.digit_in > MAX_DEC);
            combo_q <= (combo_q << DIGIT_W) | CW'(bus.digit_in);
            if (last_digit) begin
              state   <= S_IDLE;
              count_q <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          open_q   <= 1'b0;
          closed_q <= 1'b0;
          locked_q <= 1'b0;
          count_q  <= '0;
          mismatch <= 1'b0;
        end
      endcase
    end
  end

  assign bus.is_open        = open_q;
  assign bus.is_closed      = closed_q;
  assign bus.locked_out     = locked_q;
  assign bus.digit_err      = err_q;
  assign bus.digit_echo     = echo_q;
  assign bus.digits_entered = count_q;
  assign bus.fail_count     = fail_q;
  assign bus.state_out      = state;
endmodule

// File: tb/tb_param_combo_lock.sv
// Scoreboard bench for param_combo_lock: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_param_combo_lock;
  localparam int          N   = 6;
  localparam int          W   = 4;
  localparam int          MF  = 3;
  localparam int          LC  = 16;
  localparam logic [23:0] CMB = 24'h703262;
`ifdef COMBO_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  localparam int ST_IDLE = 0, ST_ENTER = 1, ST_OPEN = 2, ST_CLOSED = 3,
                 ST_LOCKOUT = 4, ST_PROG = 5;

  typedef struct packed {
    logic       is_open;
    logic       is_closed;
    logic       locked_out;
    logic       digit_err;
    logic [3:0] echo;
    logic [2:0] count;
    logic [1:0] fails;
    logic [2:0] st;
  } snap_t;

  logic clk;
  logic reset;
  param_combo_lock_if #(.NUM_DIGITS(N), .DIGIT_W(W), .MAX_FAILS(MF)) bus ();

  param_combo_lock #(
    .NUM_DIGITS(N), .DIGIT_W(W), .COMBO(CMB), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.is_open    = bus.is_open;
    s.is_closed  = bus.is_closed;
    s.locked_out = bus.locked_out;
    s.digit_err  = bus.digit_err;
    s.echo       = bus.digit_echo;
    s.count      = bus.digits_entered;
    s.fails      = bus.fail_count;
    s.st         = bus.state_out;
    return s;
  endfunction

  // ---------------- reference model ----------------
  int m_state, m_fails, m_lock_left, m_echo;
  bit m_err;
  int m_entered[$];
  int m_combo[N];

  task automatic model_reset();
    m_state = ST_IDLE; m_fails = 0; m_lock_left = 0; m_echo = 0; m_err = 0;
    m_entered.delete();
    for (int i = 0; i < N; i++) m_combo[i] = int'((CMB >> ((N - 1 - i) * W)) & 24'hF);
  endtask

  task automatic model_resolve();
    bit ok = 1'b1;
    for (int i = 0; i < N; i++)
      if (m_entered[i] != m_combo[i] || m_entered[i] > 9) ok = 1'b0;
    if (ok) begin
      m_state = ST_OPEN; m_fails = 0;
    end else if (m_fails + 1 < MF) begin
      m_state = ST_CLOSED; m_fails++;
    end else begin
      m_state = ST_LOCKOUT; m_fails = MF; m_lock_left = LC;
    end
  endtask

  task automatic model_step(input bit dv, input int d, input bit clr, input bit ps);
    case (m_state)
      ST_IDLE, ST_ENTER: if (dv) begin
        m_echo = d; m_err = (d > 9); m_entered.push_back(d);
        if (m_entered.size() == N) model_resolve(); else m_state = ST_ENTER;
      end
      ST_OPEN: begin
        if (PROG_EN && ps) begin m_state = ST_PROG; m_entered.delete(); end
        else if (clr) begin m_state = ST_IDLE; m_entered.delete(); end
      end
      ST_CLOSED: if (clr) begin m_state = ST_IDLE; m_entered.delete(); end
      ST_LOCKOUT: begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_state = ST_IDLE; m_fails = 0; m_entered.delete(); end
      end
      ST_PROG: begin
        if (clr) begin m_state = ST_IDLE; m_entered.delete(); end
        else if (dv) begin
          m_echo = d; m_err = (d > 9); m_entered.push_back(d);
          if (m_entered.size() == N) begin
            for (int i = 0; i < N; i++) m_combo[i] = m_entered[i];
            m_state = ST_IDLE; m_entered.delete();
          end
        end
      end
      default: m_state = ST_IDLE;
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.is_open    = (m_state == ST_OPEN);
    s.is_closed  = (m_state == ST_CLOSED);
    s.locked_out = (m_state == ST_LOCKOUT);
    s.digit_err  = m_err;
    s.echo       = 4'(m_echo);
    s.count      = 3'(m_entered.size());
    s.fails      = 2'(m_fails);
    s.st         = 3'(m_state);
    return s;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit dv, input int d, input bit clr, input bit ps);
    bus.digit_valid = dv;
    bus.digit_in    = 4'(d);
    bus.clear       = clr;
    bus.prog_start  = ps;
    @(posedge clk);
    #1;
    model_step(dv, d, clr, ps);
    exp_q.push_back(model_snap());
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.prog_start  = 1'b0;
  endtask

  task automatic enter(input logic [23:0] code);
    for (int i = 0; i < N; i++) step(1'b1, int'((code >> ((N - 1 - i) * W)) & 24'hF), 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: one expected snapshot per clock edge, compared half a cycle later.
  initial begin : monitor
    int cyc = 0;
    snap_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("outputs cycle %0d", cyc), 32'(dut_snap()), 32'(e));
      end
    end
  end

  initial begin : driver
    int lock_cycles;
    int wait_cnt;
    bit dv, clr, ps;
    int d;

    bus.digit_valid = 1'b0; bus.digit_in = '0; bus.clear = 1'b0; bus.prog_start = 1'b0;
    reset = 1'b1;
    model_reset();
    #12 reset = 1'b0;
    check("reset state", 32'(dut_snap()), 32'h0);

    // 1: correct code opens, clear relocks
    enter(24'h703262);
    do_clear();

    // 2: wrong last digit closes; strobe while CLOSED ignored
    enter(24'h703263);
    step(1'b1, 5, 1'b0, 1'b0);
    do_clear();

    // 3: out-of-range digit with an idle gap mid-entry
    step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 11, 1'b0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0);
    do_clear();
    enter(24'h703262);
    do_clear();

    // 4: three wrong attempts trigger a timed lockout
    enter(24'h111111); do_clear();
    enter(24'h222222); do_clear();
    enter(24'h333333);
    lock_cycles = 0;
    for (int i = 0; i < 40 && bus.locked_out; i++) begin
      lock_cycles++;
      step(1'b1, 7, 1'b1, 1'b0);
    end
    check("lockout length", 32'(lock_cycles), 32'(LC));
    enter(24'h703262);
    do_clear();

    // 5: asynchronous reset between edges mid-attempt
    enter(24'h703262); do_clear();
    step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async reset", 32'(dut_snap()), 32'h0);
    #1 reset = 1'b0;
    model_reset();
    enter(24'h703262);

    // 6: reprogramming (only meaningful with the feature built in)
    if (PROG_EN) begin
      step(1'b0, 0, 1'b0, 1'b1);
      enter(24'h123456);
      enter(24'h703262);
      do_clear();
      enter(24'h123456);
    end
    do_clear();

    // Randomised traffic biased towards correct digits
    for (int c = 0; c < 600; c++) begin
      dv  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 9) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0 && m_entered.size() < N) d = m_combo[m_entered.size()];
      else d = int'($urandom_range(0, 15));
      step(dv, d, clr, ps);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      #1 wait_cnt++;
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
